// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the set-associative instruction cache.
package cache_pkg;

    // Refill controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Tags are held at a fixed maximum width; unused upper bits stay zero
    localparam int MAX_TAG_W = 32;

    // Per-line metadata; data words live in a separate array
    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
    } line_meta_t;

    // Number of word-offset bits inside a block
    function automatic int word_bits(input int words);
        return (words > 1) ? $clog2(words) : 0;
    endfunction

    // Number of set-index bits
    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    // Number of tag bits left above byte offset, word offset and index
    function automatic int tag_bits(input int addr_w, input int words, input int sets);
        return addr_w - 2 - word_bits(words) - index_bits(sets);
    endfunction

    // Vector width for a field that may be zero bits wide
    function automatic int field_w(input int bits);
        return (bits > 0) ? bits : 1;
    endfunction

endpackage

// File: rtl/cache_tag_match.sv
// Per-set hit detection, hit-way select and victim selection.
module cache_tag_match #(
    parameter int WAYS  = 2,
    parameter int TAG_W = 32,
    parameter int WAY_W = 1
) (
    input  logic [WAYS-1:0]       valid_i,
    input  logic [WAYS*TAG_W-1:0] tags_i,
    input  logic [TAG_W-1:0]      tag_i,
    input  logic [WAY_W-1:0]      ptr_i,
    output logic                  hit_o,
    output logic [WAY_W-1:0]      hit_way_o,
    output logic [WAY_W-1:0]      victim_way_o,
    output logic                  all_valid_o
);

    logic [WAYS-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_cmp
            assign match[gi] = valid_i[gi] && (tags_i[gi*TAG_W +: TAG_W] == tag_i);
        end
    endgenerate

    assign hit_o       = |match;
    assign all_valid_o = &valid_i;

    // Lowest matching way wins; victim is the lowest free way, else the pointer's way
    always_comb begin
        hit_way_o    = '0;
        victim_way_o = ptr_i;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (match[i])    hit_way_o    = WAY_W'(i);
            if (!valid_i[i]) victim_way_o = WAY_W'(i);
        end
    end

endmodule

// File: rtl/cache_set_assoc.sv
// N-way set-associative instruction cache with burst refill and hit/miss counters.
// Optional macro CACHE_FLUSH_EN adds a FLUSH input that invalidates every line.
module cache_set_assoc
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SETS   = 8,
    parameter int WAYS   = 2,
    parameter int WORDS  = 4,
    parameter int CNT_W  = 20
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ,
    input  logic [ADDR_W-1:0] ADDR,
    output logic              READY,
    output logic              RVALID,
    output logic [DATA_W-1:0] RDATA,
    output logic              MM_REQ,
    output logic [ADDR_W-1:0] MM_ADDR,
    input  logic              MM_VALID,
    input  logic [DATA_W-1:0] MM_DATA,
`ifdef CACHE_FLUSH_EN
    input  logic              FLUSH,
`endif
    output logic [CNT_W-1:0]  CNT_HIT,
    output logic [CNT_W-1:0]  CNT_MISS
);

    localparam int WO      = word_bits(WORDS);
    localparam int IDX_W   = index_bits(SETS);
    localparam int WOFF_W  = field_w(WO);
    localparam int WAY_W   = field_w($clog2(WAYS));
    localparam int BLK_LSB = 2 + WO;
    localparam int TAG_LSB = BLK_LSB + IDX_W;
    localparam int DEPTH   = SETS * WAYS * WORDS;
    localparam int DA_W    = $clog2(DEPTH);

    state_t              state_q, state_d;
    line_meta_t          meta_q [SETS][WAYS];
    logic [WAY_W-1:0]    ptr_q  [SETS];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic                rvalid_q, mm_req_q, lat_allv_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   mm_addr_q;
    logic [WOFF_W-1:0]   beat_q, lat_word_q;
    logic [IDX_W-1:0]    lat_idx_q;
    logic [WAY_W-1:0]    lat_way_q;
    logic [MAX_TAG_W-1:0] lat_tag_q;
    logic [CNT_W-1:0]    cnt_hit_q, cnt_miss_q;

    logic [WOFF_W-1:0]   req_word;
    logic [IDX_W-1:0]    req_idx;
    logic [MAX_TAG_W-1:0] req_tag;
    logic [WAYS-1:0]     set_valid;
    logic [WAYS*MAX_TAG_W-1:0] set_tags;
    logic                hit, all_valid, flush_req;
    logic [WAY_W-1:0]    hit_way, victim_way;
    logic                hit_acc, miss_acc, beat_wr, last_beat;
    logic [DA_W-1:0]     rd_addr, wr_addr;

    // Flat data-array address of one word of one line
    function automatic logic [DA_W-1:0] data_addr(input logic [IDX_W-1:0]  idx,
                                                  input logic [WAY_W-1:0]  way,
                                                  input logic [WOFF_W-1:0] word);
        return DA_W'((int'(idx) * WAYS + int'(way)) * WORDS + int'(word));
    endfunction

    assign req_word = WOFF_W'(ADDR >> 2) & WOFF_W'(WORDS - 1);
    assign req_idx  = IDX_W'(ADDR >> BLK_LSB);
    assign req_tag  = MAX_TAG_W'(ADDR >> TAG_LSB);

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_set_rd
            assign set_valid[gi] = meta_q[req_idx][gi].valid;
            assign set_tags[gi*MAX_TAG_W +: MAX_TAG_W] = meta_q[req_idx][gi].tag;
        end
    endgenerate

    cache_tag_match #(
        .WAYS  (WAYS),
        .TAG_W (MAX_TAG_W),
        .WAY_W (WAY_W)
    ) u_tag_match (
        .valid_i      (set_valid),
        .tags_i       (set_tags),
        .tag_i        (req_tag),
        .ptr_i        ((WAYS > 1) ? ptr_q[req_idx] : WAY_W'(0)),
        .hit_o        (hit),
        .hit_way_o    (hit_way),
        .victim_way_o (victim_way),
        .all_valid_o  (all_valid)
    );

`ifdef CACHE_FLUSH_EN
    logic flush_pend_q;

    // A flush seen outside IDLE is remembered until the controller is back in IDLE
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                        flush_pend_q <= 1'b0;
        else if (state_q == IDLE)            flush_pend_q <= 1'b0;
        else if (FLUSH)                      flush_pend_q <= 1'b1;
    end

    assign flush_req = (state_q == IDLE) && (FLUSH || flush_pend_q);
`else
    assign flush_req = 1'b0;
`endif

    // Next state and one-cycle action strobes; flush takes priority over a request
    always_comb begin
        state_d   = state_q;
        hit_acc   = 1'b0;
        miss_acc  = 1'b0;
        beat_wr   = 1'b0;
        last_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flush_req && REQ) begin
                    if (hit) begin
                        hit_acc = 1'b1;
                    end else begin
                        miss_acc = 1'b1;
                        state_d  = REFILL;
                    end
                end
            end
            REFILL: begin
                if (MM_VALID) begin
                    beat_wr = 1'b1;
                    if (beat_q == WOFF_W'(WORDS - 1)) begin
                        last_beat = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rd_addr = (state_q == IDLE) ? data_addr(req_idx, hit_way, req_word)
                                       : data_addr(lat_idx_q, lat_way_q, lat_word_q);
    assign wr_addr = data_addr(lat_idx_q, lat_way_q, beat_q);

    // Data words: written by refill beats only, never cleared
    always_ff @(posedge CLK) begin
        if (beat_wr) data_q[wr_addr] <= MM_DATA;
    end

    // Controller, metadata, pointers and counters
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            mm_req_q   <= 1'b0;
            mm_addr_q  <= '0;
            beat_q     <= '0;
            lat_idx_q  <= '0;
            lat_way_q  <= '0;
            lat_word_q <= '0;
            lat_tag_q  <= '0;
            lat_allv_q <= 1'b0;
            cnt_hit_q  <= '0;
            cnt_miss_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) meta_q[s][w].valid <= 1'b0;
            end
        end else begin
            state_q  <= state_d;
            rvalid_q <= hit_acc || (state_q == RESP);
            if (hit_acc || (state_q == RESP)) rdata_q <= data_q[rd_addr];
            if (hit_acc && (cnt_hit_q != {CNT_W{1'b1}})) cnt_hit_q <= cnt_hit_q + 1'b1;
            if (miss_acc) begin
                if (cnt_miss_q != {CNT_W{1'b1}}) cnt_miss_q <= cnt_miss_q + 1'b1;
                lat_tag_q  <= req_tag;
                lat_idx_q  <= req_idx;
                lat_word_q <= req_word;
                lat_way_q  <= victim_way;
                lat_allv_q <= all_valid;
                mm_addr_q  <= ADDR_W'((ADDR >> BLK_LSB) << BLK_LSB);
                mm_req_q   <= 1'b1;
                beat_q     <= '0;
            end
            if (beat_wr) beat_q <= beat_q + 1'b1;
            if (last_beat) begin
                mm_req_q <= 1'b0;
                meta_q[lat_idx_q][lat_way_q] <= '{valid: 1'b1, tag: lat_tag_q};
                if ((WAYS > 1) && lat_allv_q) ptr_q[lat_idx_q] <= ptr_q[lat_idx_q] + 1'b1;
            end
            if (flush_req) begin
                for (int s = 0; s < SETS; s++) begin
                    ptr_q[s] <= '0;
                    for (int w = 0; w < WAYS; w++) meta_q[s][w].valid <= 1'b0;
                end
            end
        end
    end

    assign READY    = (state_q == IDLE);
    assign RVALID   = rvalid_q;
    assign RDATA    = rdata_q;
    assign MM_REQ   = mm_req_q;
    assign MM_ADDR  = mm_addr_q;
    assign CNT_HIT  = cnt_hit_q;
    assign CNT_MISS = cnt_miss_q;

endmodule

// File: tb/tb_cache_set_assoc.sv
// Directed bench for cache_set_assoc with a response scoreboard.
module tb_cache_set_assoc;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WORDS  = 4;
    localparam int CNT_W  = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              REQ = 1'b0;
    logic [ADDR_W-1:0] ADDR = '0;
    logic              MM_VALID = 1'b0;
    logic [DATA_W-1:0] MM_DATA = '0;
`ifdef CACHE_FLUSH_EN
    logic              FLUSH = 1'b0;
`endif
    logic              READY, RVALID, MM_REQ;
    logic [DATA_W-1:0] RDATA;
    logic [ADDR_W-1:0] MM_ADDR;
    logic [CNT_W-1:0]  CNT_HIT, CNT_MISS;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_hit  = 0;
    int exp_miss = 0;
    logic [31:0] exp_q [$];

    cache_set_assoc #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .SETS (8), .WAYS (2),
        .WORDS (WORDS), .CNT_W (CNT_W)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .REQ      (REQ),
        .ADDR     (ADDR),
        .READY    (READY),
        .RVALID   (RVALID),
        .RDATA    (RDATA),
        .MM_REQ   (MM_REQ),
        .MM_ADDR  (MM_ADDR),
        .MM_VALID (MM_VALID),
        .MM_DATA  (MM_DATA),
`ifdef CACHE_FLUSH_EN
        .FLUSH    (FLUSH),
`endif
        .CNT_HIT  (CNT_HIT),
        .CNT_MISS (CNT_MISS)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a >> 2) & 32'(WORDS - 1);
    endfunction

    task automatic pop_check(input string tag);
        logic [31:0] e;
        check({tag, "_rvalid"}, 32'(RVALID), 32'd1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s_sb observed=response expected=none pending", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, RDATA, e);
        end
    endtask

    task automatic do_hit(input logic [31:0] addr, input logic [31:0] data);
        REQ  = 1'b1;
        ADDR = addr;
        exp_q.push_back(data);
        exp_hit = sat(exp_hit);
        tick();
        REQ = 1'b0;
        pop_check("hit");
        check("hit_ready", 32'(READY), 32'd1);
        check("hit_mmreq", 32'(MM_REQ), 32'd0);
        check("hit_cnt", 32'(CNT_HIT), 32'(exp_hit));
        check("hit_misscnt", 32'(CNT_MISS), 32'(exp_miss));
        $display("hit  addr=0x%08h rdata=0x%08h cnt_hit=%0d", addr, RDATA, CNT_HIT);
    endtask

    task automatic do_miss(input logic [31:0] addr, input logic [31:0] base,
                           input int gap, input logic noise);
        REQ  = 1'b1;
        ADDR = addr;
        exp_q.push_back(base + word_of(addr));
        exp_miss = sat(exp_miss);
        tick();
        REQ = 1'b0;
        check("miss_mmreq", 32'(MM_REQ), 32'd1);
        check("miss_mmaddr", MM_ADDR, addr & ~32'hF);
        check("miss_ready", 32'(READY), 32'd0);
        check("miss_cnt", 32'(CNT_MISS), 32'(exp_miss));
        for (int b = 0; b < WORDS; b++) begin
            for (int g = 0; g < gap; g++) begin
                REQ  = noise;
                ADDR = addr ^ 32'h40;
                tick();
                check("stall_ready", 32'(READY), 32'd0);
                check("stall_mmreq", 32'(MM_REQ), 32'd1);
            end
            REQ      = 1'b0;
            MM_VALID = 1'b1;
            MM_DATA  = base + 32'(b);
            tick();
            MM_VALID = 1'b0;
        end
        check("resp_mmreq", 32'(MM_REQ), 32'd0);
        check("resp_ready", 32'(READY), 32'd0);
        check("resp_rvalid", 32'(RVALID), 32'd0);
        tick();
        pop_check("miss");
        check("done_ready", 32'(READY), 32'd1);
        check("done_hitcnt", 32'(CNT_HIT), 32'(exp_hit));
        check("done_misscnt", 32'(CNT_MISS), 32'(exp_miss));
        $display("miss addr=0x%08h rdata=0x%08h cnt_miss=%0d", addr, RDATA, CNT_MISS);
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        check("rst_ready", 32'(READY), 32'd1);
        check("rst_rvalid", 32'(RVALID), 32'd0);
        check("rst_rdata", RDATA, 32'd0);
        check("rst_mmreq", 32'(MM_REQ), 32'd0);
        check("rst_mmaddr", MM_ADDR, 32'd0);
        check("rst_cnthit", 32'(CNT_HIT), 32'd0);
        check("rst_cntmiss", 32'(CNT_MISS), 32'd0);
        RESET_N = 1'b1;
        tick();

        // Basic miss, then hit on the last word of the block
        do_miss(32'h40, 32'hA0, 0, 1'b0);
        do_hit(32'h4C, 32'hA3);

        // Three tags contending for set 4
        do_miss(32'h140, 32'hB0, 0, 1'b0);
        do_hit(32'h40, 32'hA0);
        do_hit(32'h144, 32'hB1);
        do_miss(32'h240, 32'hC0, 0, 1'b0);
        do_hit(32'h144, 32'hB1);
        do_miss(32'h048, 32'hD0, 0, 1'b0);
        do_hit(32'h244, 32'hC1);
        do_hit(32'h04C, 32'hD3);
        do_miss(32'h140, 32'hE0, 0, 1'b0);
        do_hit(32'h048, 32'hD2);

        // Refill with gaps and ignored requests during the stall
        do_miss(32'h1008, 32'hF0, 3, 1'b1);
        do_hit(32'h1000, 32'hF0);
        do_hit(32'h100C, 32'hF3);
        do_hit(32'h1004, 32'hF1);

        // Reset in the middle of a refill
        REQ  = 1'b1;
        ADDR = 32'h3020;
        tick();
        REQ = 1'b0;
        for (int b = 0; b < 2; b++) begin
            MM_VALID = 1'b1;
            MM_DATA  = 32'h99;
            tick();
            MM_VALID = 1'b0;
        end
        RESET_N = 1'b0;
        #1;
        check("arst_mmreq", 32'(MM_REQ), 32'd0);
        check("arst_ready", 32'(READY), 32'd1);
        check("arst_cntmiss", 32'(CNT_MISS), 32'd0);
        check("arst_cnthit", 32'(CNT_HIT), 32'd0);
        exp_q.delete();
        exp_hit  = 0;
        exp_miss = 0;
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
        do_miss(32'h3020, 32'h50, 0, 1'b0);

        // Hit counter saturation
        for (int i = 0; i < CNT_MAX + 3; i++) do_hit(32'h3024, 32'h51);
        check("sat_hit", 32'(CNT_HIT), 32'(CNT_MAX));
        check("sat_miss", 32'(CNT_MISS), 32'd1);

`ifdef CACHE_FLUSH_EN
        // Flush in IDLE, then a flush with a simultaneous request
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        check("flush_cnthit", 32'(CNT_HIT), 32'(exp_hit));
        check("flush_cntmiss", 32'(CNT_MISS), 32'(exp_miss));
        do_miss(32'h3024, 32'h60, 0, 1'b0);
        FLUSH = 1'b1;
        REQ   = 1'b1;
        ADDR  = 32'h3028;
        tick();
        FLUSH = 1'b0;
        REQ   = 1'b0;
        check("flushreq_rvalid", 32'(RVALID), 32'd0);
        check("flushreq_mmreq", 32'(MM_REQ), 32'd0);
        check("flushreq_cntmiss", 32'(CNT_MISS), 32'(exp_miss));
        // Flush during refill applies after the response
        REQ  = 1'b1;
        ADDR = 32'h5000;
        exp_q.push_back(32'h70);
        exp_miss = sat(exp_miss);
        tick();
        REQ   = 1'b0;
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        for (int b = 0; b < WORDS; b++) begin
            MM_VALID = 1'b1;
            MM_DATA  = 32'h70 + 32'(b);
            tick();
            MM_VALID = 1'b0;
        end
        tick();
        pop_check("pend");
        tick();
        do_miss(32'h5000, 32'h80, 0, 1'b0);
`endif

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
